// File: rtl/tdm_pkg.sv
// Shared TDM link definitions for the 4:1 mux/demux family: default frame
// geometry, receiver framing states and the error-counter helper.
package tdm_pkg;

    localparam int NCH_DEF     = 4;
    localparam int SEL_W_DEF   = $clog2(NCH_DEF);
    localparam int ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Receiver framing state: hunting for a marker, or tracking slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Saturating increment: the error count sticks at all-ones, never wraps.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot-index counter: wraps naturally at 2**SEL_W, can be cleared to 0 or
// loaded with 1 (the slot that follows a frame marker).
module tdm_slot_ctr #(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt
);

    localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

    // Counter register; clear beats load, load beats increment.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load1)
            cnt <= ONE;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tdm_demux_4_1.sv
// TDM receiver: locks onto the frame marker, captures each slot into a
// shadow register and publishes a whole frame on a in a single cycle.
module tdm_demux_4_1
    import tdm_pkg::*;
#(
    parameter  int NCH    = NCH_DEF,
    parameter  int DATA_W = 1,
    localparam int SEL_W  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    input  logic [DATA_W-1:0]     din,
    output logic [NCH*DATA_W-1:0] a,
    output logic [SEL_W-1:0]      s,
    output logic                  frame_valid,
    output logic                  locked,
    output logic                  sync_err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

    state_t            state, state_nxt;
    logic              ctr_clr, ctr_load1, ctr_inc;
    logic              cap_en;
    logic [SEL_W-1:0]  cap_idx;
    logic              publish;
    logic              err;
    logic [DATA_W-1:0] shadow [NCH];

    tdm_slot_ctr #(.SEL_W(SEL_W)) u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .cnt   (s)
    );

    // Framing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    // Next-state and per-slot control decode; nothing happens without en.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        ctr_clr   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;
        cap_en    = 1'b0;
        cap_idx   = '0;
        publish   = 1'b0;
        err       = 1'b0;
        if (en) begin
            unique case (state)
                HUNT: begin
                    // Unsynced slots are ignored silently while hunting.
                    if (sync) begin
                        cap_en    = 1'b1;
                        ctr_load1 = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (s == '0) begin
                        if (sync) begin
                            cap_en    = 1'b1;
                            ctr_load1 = 1'b1;
                        end else begin
                            // Missing marker: drop lock and hunt again.
                            err       = 1'b1;
                            ctr_clr   = 1'b1;
                            state_nxt = HUNT;
                        end
                    end else if (sync) begin
                        // Early marker: abandon the partial frame and
                        // restart it at slot 0 without losing lock.
                        err       = 1'b1;
                        cap_en    = 1'b1;
                        ctr_load1 = 1'b1;
                    end else begin
                        cap_en  = 1'b1;
                        cap_idx = s;
                        ctr_inc = 1'b1;
                        publish = (s == LAST_SLOT);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Shadow capture of the current slot sample.
    // NOTE: the shadow array is small and its reset value is observable
    // behaviour, so it is reset explicitly rather than left as plain RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++)
                shadow[k] <= '0;
        end else if (cap_en) begin
            shadow[cap_idx] <= din;
        end
    end

    // Atomic frame publish: the last slot goes straight from din, the rest
    // from the shadow, so a never shows a partially assembled frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
        end else if (publish) begin
            for (int k = 0; k < NCH - 1; k++)
                a[k*DATA_W +: DATA_W] <= shadow[k];
            a[(NCH-1)*DATA_W +: DATA_W] <= din;
        end
    end

    // Status pulses and the saturating framing-error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= publish;
            sync_err    <= err;
            if (err)
                err_cnt <= sat_inc(err_cnt);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4_1.sv
// Self-checking bench for tdm_demux_4_1: directed slot stream, expected
// frames and error counts queued by the stimulus, compared by a monitor.
module tb_tdm_demux_4_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [0:0] din = 1'b0;
    logic [3:0] a;
    logic [1:0] s;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_frames [$];
    logic [7:0] exp_errs   [$];
    int         err_model = 0;

    tdm_demux_4_1 dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .din         (din),
        .a           (a),
        .s           (s),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One strobed slot, driven at the falling edge and taken at the next rising edge.
    task automatic send(input bit sy, input bit d);
        @(negedge clk);
        en   = 1'b1;
        sync = sy;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en   = 1'b0;
            sync = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [3:0] f);
        exp_frames.push_back(f);
    endtask

    task automatic expect_err();
        if (err_model < 255)
            err_model++;
        exp_errs.push_back(8'(err_model));
    endtask

    // Monitor: compares every published frame and every error pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_valid || sync_err)
                check("pulse_exclusive", {31'd0, frame_valid & sync_err}, 32'd0);
            if (frame_valid) begin
                if (exp_frames.size() == 0)
                    check("unexpected_frame", {28'd0, a}, 32'hFFFF_FFFF);
                else
                    check("frame", {28'd0, a}, {28'd0, exp_frames.pop_front()});
            end
            if (sync_err) begin
                if (exp_errs.size() == 0)
                    check("unexpected_sync_err", {24'd0, err_cnt}, 32'hFFFF_FFFF);
                else
                    check("err_cnt_at_pulse", {24'd0, err_cnt}, {24'd0, exp_errs.pop_front()});
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_a", {28'd0, a}, 32'd0);
        check("reset_s", {30'd0, s}, 32'd0);
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("reset_fv", {31'd0, frame_valid}, 32'd0);

        // Unsynced slots while hunting are ignored.
        send(0, 1);
        check("hunt_ignore_s", {30'd0, s}, 32'd0);
        check("hunt_ignore_locked", {31'd0, locked}, 32'd0);

        // Clean back-to-back frames.
        send(1, 1);
        check("lock_s", {30'd0, s}, 32'd1);
        check("lock_locked", {31'd0, locked}, 32'd1);
        send(0, 0);
        send(0, 1);
        expect_frame(4'b1101);
        send(0, 1);
        send(1, 0);
        send(0, 1);
        send(0, 0);
        expect_frame(4'b0010);
        send(0, 0);
        check("clean_s_wrap", {30'd0, s}, 32'd0);
        check("clean_locked", {31'd0, locked}, 32'd1);
        check("clean_err_cnt", {24'd0, err_cnt}, 32'd0);
        idle(1);
        check("clean_a_hold", {28'd0, a}, 32'h2);

        // Gapped strobes: s holds during gaps.
        send(1, 1);
        idle(2);
        check("gap_s_hold", {30'd0, s}, 32'd1);
        send(0, 0);
        idle(2);
        check("gap_s_hold2", {30'd0, s}, 32'd2);
        send(0, 1);
        idle(2);
        expect_frame(4'b1101);
        send(0, 1);
        idle(2);
        check("gap_a", {28'd0, a}, 32'hD);

        // Early sync at slot 2.
        send(1, 1);
        send(0, 1);
        expect_err();
        send(1, 0);
        check("early_s", {30'd0, s}, 32'd1);
        check("early_locked", {31'd0, locked}, 32'd1);
        check("early_a_unchanged", {28'd0, a}, 32'hD);
        send(0, 1);
        send(0, 1);
        expect_frame(4'b1110);
        send(0, 1);
        check("early_err_cnt", {24'd0, err_cnt}, 32'd1);

        // Missing sync at slot 0, ignored slots, relock.
        expect_err();
        send(0, 1);
        check("miss_locked", {31'd0, locked}, 32'd0);
        check("miss_s", {30'd0, s}, 32'd0);
        send(0, 1);
        send(0, 0);
        check("miss_ignore_s", {30'd0, s}, 32'd0);
        check("miss_err_cnt", {24'd0, err_cnt}, 32'd2);
        send(1, 0);
        check("relock_locked", {31'd0, locked}, 32'd1);
        send(0, 1);
        send(0, 0);
        expect_frame(4'b1010);
        send(0, 1);

        // Asynchronous reset mid-frame, between clock edges.
        send(1, 1);
        send(0, 1);
        @(negedge clk);
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a", {28'd0, a}, 32'd0);
        check("async_rst_s", {30'd0, s}, 32'd0);
        check("async_rst_locked", {31'd0, locked}, 32'd0);
        check("async_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        err_model = 0;
        @(negedge clk);
        rst = 1'b0;
        send(1, 1);
        check("post_rst_lock", {31'd0, locked}, 32'd1);
        send(0, 0);
        send(0, 0);
        expect_frame(4'b1001);
        send(0, 1);

        // Error counter saturation via repeated early syncs.
        send(1, 0);
        for (int i = 0; i < 300; i++) begin
            expect_err();
            send(1, 0);
        end
        idle(2);
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
        check("sat_locked", {31'd0, locked}, 32'd1);
        check("sat_a_unchanged", {28'd0, a}, 32'h9);

        // Every queued expectation must have been consumed.
        idle(3);
        check("frames_outstanding", exp_frames.size(), 32'd0);
        check("errs_outstanding", exp_errs.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
